// File: rtl/tp_line_arbiter_pkg.sv
// Shared definitions for the teleprinter line arbiter.
// State encoding, line-control characters and index-width helper.
package tp_line_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } tp_state_e;

  localparam logic [7:0] TP_EOL = 8'h0A;
  localparam logic [7:0] TP_CR  = 8'h0D;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tp_line_arbiter_rr_select.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
// Purely combinational, reusable by other peripheral arbiters.
module rr_select
  import tp_line_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any       = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tp_line_arbiter.sv
// Shares one UART transmitter between NUM_REQ character sources.
// A granted source keeps the line until EOL, MAX_LINE chars or a stall timeout.
module tp_line_arbiter
  import tp_line_arbiter_pkg::*;
#(
  parameter int                NUM_REQ  = 2,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] EOL_CHAR = DATA_W'(TP_EOL),
  parameter int                MAX_LINE = 80,
  parameter int                TIMEOUT  = 1023
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        timeout_pulse
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(MAX_LINE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  tp_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       char_cnt_q, char_cnt_d;
  logic [TW-1:0]       idle_cnt_q, idle_cnt_d;
  logic                tmo_q, tmo_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                locked;
  logic                own_valid;
  logic                xfer;
  logic [CW-1:0]       cnt_inc;
  logic [IW-1:0]       ptr_next;

  rr_select #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign locked    = (state_q == ST_LOCKED);
  assign own_valid = req_valid[gidx_q];
  assign tx_valid  = locked & own_valid;
  assign tx_data   = locked ? req_data[int'(gidx_q)*DATA_W +: DATA_W]
                            : '0;
  assign req_ready = (locked && tx_ready) ? grant_q : '0;
  assign grant     = grant_q;
  assign timeout_pulse = tmo_q;

  assign xfer     = tx_valid & tx_ready;
  assign cnt_inc  = char_cnt_q + CW'(1);
  assign ptr_next = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    char_cnt_d = char_cnt_q;
    idle_cnt_d = idle_cnt_q;
    tmo_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_LOCKED;
          grant_d = pick_oh;
          gidx_d  = pick_idx;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          char_cnt_d = cnt_inc;
          idle_cnt_d = '0;
        end else if (own_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + TW'(1);
        end
        // Releasing char still goes out; the lock drops on the next edge.
        if ((xfer && (tx_data == EOL_CHAR)) ||
            (xfer && (cnt_inc == CW'(MAX_LINE))) ||
            (!own_valid && (idle_cnt_q == TW'(TIMEOUT - 1)))) begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          rr_ptr_d   = ptr_next;
          char_cnt_d = '0;
          idle_cnt_d = '0;
          tmo_d      = !xfer;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      char_cnt_q <= '0;
      idle_cnt_q <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      char_cnt_q <= char_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule
